// File: rtl/instr_decode_exec.sv
// instr_decode_exec: two-stage decode/execute/write-back unit of the 8-bit teaching CPU.
//
// Stage 1 latches the fetched instruction into IR every cycle. There is no stall.
// Stage 2 decodes IR, reads two operands from an 8x8 register file and computes a
// MOV/ADD/SUB result. The register write, the flags and the result outputs all commit
// on the following edge. JMP (opcode 11) is resolved by fetch, so here it is a bubble.
//
// Ports:
//   clk              rising-edge clock shared with fetch
//   reset            synchronous, active-high reset
//   Instruction_code [7:6] opcode, [5:3] rd, [2:0] rs
//   instr_valid      Instruction_code is valid this cycle (low inserts a bubble)
//   dbg_addr         debug register-file read address
//   dbg_data         combinational R[dbg_addr], committed state only
//   result           last written-back value (registered)
//   result_valid     one-cycle pulse following each write-back edge
//   wb_addr          destination register of the last write-back (registered)
//   zero_flag        registered Z
//   carry_flag       registered C (carry for ADD, borrow for SUB)
module instr_decode_exec #(
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        Instruction_code,
  input  logic              instr_valid,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [2:0]        wb_addr,
  output logic              zero_flag,
  output logic              carry_flag
);

  typedef enum logic [1:0] {
    OpMov = 2'b00,
    OpAdd = 2'b01,
    OpSub = 2'b10,
    OpJmp = 2'b11
  } opcode_e;

  // Pipeline and architectural state
  logic [7:0]        ir_q;
  logic              ir_valid_q;
  logic [DATA_W-1:0] rf_q [REG_COUNT];
  logic [DATA_W-1:0] result_q;
  logic [2:0]        wb_addr_q;
  logic              result_valid_q;
  logic              zero_q;
  logic              carry_q;

  // Decode fields
  opcode_e           op;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // Execute results
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data_d;
  logic              zero_d;
  logic              carry_d;

  assign op   = opcode_e'(ir_q[7:6]);
  assign rd   = ir_q[5:3];
  assign rs   = ir_q[2:0];
  assign op_a = rf_q[rd];
  assign op_b = rf_q[rs];

  // Both operands are zero-extended by one bit. The top bit of the sum is the carry-out.
  // The top bit of the difference is set exactly when op_a < op_b, so it is the borrow.
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    wr_en     = 1'b0;
    wr_data_d = op_b;
    zero_d    = zero_q;
    carry_d   = carry_q;
    if (ir_valid_q) begin
      unique case (op)
        OpMov: begin
          wr_en     = 1'b1;
          wr_data_d = op_b;
          zero_d    = (op_b == '0);
        end
        OpAdd: begin
          wr_en     = 1'b1;
          wr_data_d = sum[DATA_W-1:0];
          zero_d    = (sum[DATA_W-1:0] == '0);
          carry_d   = sum[DATA_W];
        end
        OpSub: begin
          wr_en     = 1'b1;
          wr_data_d = diff[DATA_W-1:0];
          zero_d    = (diff[DATA_W-1:0] == '0);
          carry_d   = diff[DATA_W];
        end
        OpJmp: begin
          // Resolved by fetch. Nothing is written here.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q           <= 8'h00;
      ir_valid_q     <= 1'b0;
      result_q       <= '0;
      wb_addr_q      <= 3'd0;
      result_valid_q <= 1'b0;
      zero_q         <= 1'b0;
      carry_q        <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= DATA_W'(i);
      end
    end else begin
      ir_q           <= Instruction_code;
      ir_valid_q     <= instr_valid;
      result_valid_q <= wr_en;
      zero_q         <= zero_d;
      carry_q        <= carry_d;
      if (wr_en) begin
        rf_q[rd]  <= wr_data_d;
        result_q  <= wr_data_d;
        wb_addr_q <= rd;
      end
    end
  end

  // The debug port shows committed state only. A write pending in stage 2 is not forwarded.
  assign dbg_data     = rf_q[dbg_addr];
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign wb_addr      = wb_addr_q;
  assign zero_flag    = zero_q;
  assign carry_flag   = carry_q;

endmodule
